// File: rtl/spi_reg_arb_pkg.sv
// Shared types and sizing for the SPI / internal-requester register bank arbiter.
package spi_reg_arb_pkg;

  localparam int unsigned ADDR_W       = 3;
  localparam int unsigned REG_W        = 8;
  localparam int unsigned N_REQ_DEF    = 2;
  localparam int unsigned LOCK_TMO_DEF = 64;

  // Width of the lock idle timer: holds LOCK_TMO-1 down to the terminal count 0.
  function automatic int unsigned lock_cnt_w(input int unsigned tmo);
    return $clog2(tmo);
  endfunction

  localparam int unsigned LOCK_CNT_W = lock_cnt_w(LOCK_TMO_DEF);

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // SPI write parked while an internal requester holds the bank.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } spi_pend_t;

endpackage

// File: rtl/spi_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the pointer.
module spi_reg_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the farthest candidate back to the pointer so the closest valid one wins.
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= int'(N_REQ)) j = j - int'(N_REQ);
      if (i_valid[IDX_W'(j)]) begin
        o_any              = 1'b1;
        o_idx              = IDX_W'(j);
        o_grant            = '0;
        o_grant[IDX_W'(j)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Register bank shared by the SPI slave and N_REQ internal requesters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------------
//   ARB_IDLE | SPI write wins, else pending SPI write commits, else round-robin grant
//   ARB_LOCK | only the owner is served; SPI writes park in the pending buffer;
//            | idle timer forces release after LOCK_TMO cycles without an owner grant
module spi_reg_arbiter
  import spi_reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned LOCK_TMO = LOCK_TMO_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ena,
  input  logic [ADDR_W-1:0]           i_spi_addr,
  input  logic [REG_W-1:0]            i_spi_wdata,
  input  logic                        i_spi_wr_dv,
  output logic [REG_W-1:0]            o_spi_rdata,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_we,
  input  logic [N_REQ-1:0]            i_req_lock,
  input  logic [N_REQ*ADDR_W-1:0]     i_req_addr,
  input  logic [N_REQ*REG_W-1:0]      i_req_wdata,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [REG_W-1:0]            o_rsp_rdata,
  output logic [(2**ADDR_W)*REG_W-1:0] o_regs,
  output logic                        o_spi_ovf,
  output logic                        o_lock_tmo
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = lock_cnt_w(LOCK_TMO);
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(LOCK_TMO - 1);

  logic [REG_W-1:0] r_bank [DEPTH];
  arb_state_t       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_tmr;
  spi_pend_t        r_pend;
  logic             r_pend_full;
  logic             r_ovf;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [REG_W-1:0] r_rsp_rdata;

  logic             w_act;
  logic [N_REQ-1:0] w_pick_grant;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [IDX_W-1:0] w_cand_idx;
  logic             w_c_we;
  logic             w_c_lock;
  logic [ADDR_W-1:0] w_c_addr;
  logic [REG_W-1:0] w_c_wdata;

  arb_state_t       w_state_nxt;
  logic [N_REQ-1:0] w_ready;
  logic             w_tmo;
  logic             w_rd;
  logic             w_bank_we;
  logic [ADDR_W-1:0] w_bank_addr;
  logic [REG_W-1:0] w_bank_data;
  logic             w_pend_load;
  logic             w_pend_clr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [CNT_W-1:0] w_tmr_nxt;

  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= int'(N_REQ) - 1) return '0;
    return idx + 1'b1;
  endfunction

  assign w_act = i_ena & ~i_rst;

  spi_reg_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // The requester that could be served this cycle: the owner while locked, else the rr pick.
  assign w_cand_idx = (r_state == ARB_LOCK) ? r_owner : w_pick_idx;
  assign w_c_we     = i_req_we[w_cand_idx];
  assign w_c_lock   = i_req_lock[w_cand_idx];
  assign w_c_addr   = i_req_addr[w_cand_idx*ADDR_W +: ADDR_W];
  assign w_c_wdata  = i_req_wdata[w_cand_idx*REG_W +: REG_W];

  // Next-state, grant and bank-write selection.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_tmo       = 1'b0;
    w_rd        = 1'b0;
    w_bank_we   = 1'b0;
    w_bank_addr = i_spi_addr;
    w_bank_data = i_spi_wdata;
    w_pend_load = 1'b0;
    w_pend_clr  = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_tmr_nxt   = r_tmr;
    if (w_act) begin
      case (r_state)
        ARB_IDLE: begin
          if (i_spi_wr_dv) begin
            w_bank_we = 1'b1;
          end else if (r_pend_full) begin
            w_bank_we   = 1'b1;
            w_bank_addr = r_pend.addr;
            w_bank_data = r_pend.data;
            w_pend_clr  = 1'b1;
          end else if (w_pick_any) begin
            w_ready   = w_pick_grant;
            w_ptr_nxt = f_inc(w_pick_idx);
            if (w_c_we) begin
              w_bank_we   = 1'b1;
              w_bank_addr = w_c_addr;
              w_bank_data = w_c_wdata;
            end else begin
              w_rd = 1'b1;
            end
            if (w_c_lock) begin
              w_state_nxt = ARB_LOCK;
              w_owner_nxt = w_pick_idx;
              w_tmr_nxt   = TMR_LOAD;
            end
          end
        end
        ARB_LOCK: begin
          w_pend_load = i_spi_wr_dv;
          if (r_tmr == '0) begin
            // Forced release wins over a late owner request in the same cycle.
            w_tmo       = 1'b1;
            w_state_nxt = ARB_IDLE;
          end else if (i_req_valid[r_owner]) begin
            w_ready[r_owner] = 1'b1;
            if (w_c_we) begin
              w_bank_we   = 1'b1;
              w_bank_addr = w_c_addr;
              w_bank_data = w_c_wdata;
            end else begin
              w_rd = 1'b1;
            end
            if (w_c_lock) begin
              w_tmr_nxt = TMR_LOAD;
            end else begin
              w_state_nxt = ARB_IDLE;
              w_ptr_nxt   = f_inc(r_owner);
            end
          end else begin
            w_tmr_nxt = r_tmr - 1'b1;
          end
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

  // Arbiter state, pending buffer, flags and read response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_tmr       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_ovf       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else if (i_ena) begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_ptr       <= w_ptr_nxt;
      r_tmr       <= w_tmr_nxt;
      r_rsp_valid <= w_rd ? w_ready : '0;
      if (w_rd) r_rsp_rdata <= r_bank[w_c_addr];
      if (w_pend_load) begin
        r_pend.addr <= i_spi_addr;
        r_pend.data <= i_spi_wdata;
        r_pend_full <= 1'b1;
        if (r_pend_full) r_ovf <= 1'b1;
      end else if (w_pend_clr) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  // Register bank storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int a = 0; a < int'(DEPTH); a++) r_bank[a] <= '0;
    end else if (w_bank_we) begin
      r_bank[w_bank_addr] <= w_bank_data;
    end
  end

  for (genvar a = 0; a < DEPTH; a++) begin : g_regs
    assign o_regs[a*REG_W +: REG_W] = r_bank[a];
  end

  assign o_spi_rdata = r_bank[i_spi_addr];
  assign o_req_ready = w_ready;
  assign o_rsp_valid = r_rsp_valid & {N_REQ{w_act}};
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_spi_ovf   = r_ovf;
  assign o_lock_tmo  = w_tmo;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed + randomized bench with a cycle-level behavioural model of the bank arbiter.
module tb_spi_reg_arbiter;

  localparam int N   = 2;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [2:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_wr_dv;
  logic [7:0]  spi_rdata;
  logic [1:0]  req_valid, req_we, req_lock;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [63:0] regs;
  logic        spi_ovf, lock_tmo;

  spi_reg_arbiter #(.N_REQ(N), .LOCK_TMO(TMO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ena       (ena),
    .i_spi_addr  (spi_addr),
    .i_spi_wdata (spi_wdata),
    .i_spi_wr_dv (spi_wr_dv),
    .o_spi_rdata (spi_rdata),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_lock  (req_lock),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_regs      (regs),
    .o_spi_ovf   (spi_ovf),
    .o_lock_tmo  (lock_tmo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic [7:0]  m_bank [8];
  int          m_ptr    = 0;
  bit          m_locked = 1'b0;
  int          m_owner  = 0;
  int          m_idle   = 0;
  logic [10:0] m_pend [$];
  bit          m_ovf    = 1'b0;
  logic [1:0]  m_rspv   = 2'b00;
  logic [1:0]  m_rspv_n;
  logic [7:0]  m_rspd   = 8'h00;

  // Expected outputs for the cycle being sampled.
  logic [1:0]  e_ready, e_rspv;
  logic        e_tmo, e_ovf;
  logic [7:0]  e_rspd, e_spi_rdata;
  logic [63:0] e_regs;

  // Observed outputs captured at the last sample point.
  logic [1:0]  s_ready, s_rspv;
  logic        s_tmo;

  initial for (int a = 0; a < 8; a++) m_bank[a] = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 8; a++) m_bank[a] = 8'h00;
    m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_idle = 0;
    m_pend.delete();
    m_ovf = 1'b0; m_rspv = 2'b00; m_rspd = 8'h00;
  endtask

  task automatic serve(input int g);
    logic [2:0] a;
    a = req_addr[g*3 +: 3];
    e_ready[1'(g)] = 1'b1;
    if (req_we[1'(g)]) m_bank[a] = req_wdata[g*8 +: 8];
    else begin
      m_rspd = m_bank[a];
      m_rspv_n[1'(g)] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int a = 0; a < 8; a++) e_regs[a*8 +: 8] = m_bank[a];
    e_spi_rdata = m_bank[spi_addr];
    e_rspd  = m_rspd;
    e_ovf   = m_ovf;
    e_rspv  = (ena && !rst) ? m_rspv : 2'b00;
    e_ready = 2'b00;
    e_tmo   = 1'b0;
    if (rst) model_reset();
    else if (ena) begin
      m_rspv_n = 2'b00;
      if (!m_locked) begin
        if (spi_wr_dv) m_bank[spi_addr] = spi_wdata;
        else if (m_pend.size() > 0) begin
          m_bank[m_pend[0][10:8]] = m_pend[0][7:0];
          m_pend.delete();
        end else begin
          int g;
          g = -1;
          for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[1'((m_ptr + k) % N)]) g = (m_ptr + k) % N;
          if (g >= 0) begin
            serve(g);
            m_ptr = (g + 1) % N;
            if (req_lock[1'(g)]) begin
              m_locked = 1'b1; m_owner = g; m_idle = 0;
            end
          end
        end
      end else begin
        if (spi_wr_dv) begin
          if (m_pend.size() > 0) begin
            m_ovf = 1'b1;
            m_pend.delete();
          end
          m_pend.push_back({spi_addr, spi_wdata});
        end
        if (m_idle == TMO - 1) begin
          e_tmo = 1'b1;
          m_locked = 1'b0;
        end else if (req_valid[1'(m_owner)]) begin
          serve(m_owner);
          m_idle = 0;
          if (!req_lock[1'(m_owner)]) begin
            m_locked = 1'b0;
            m_ptr = (m_owner + 1) % N;
          end
        end else m_idle++;
      end
      m_rspv = m_rspv_n;
    end
  endtask

  // One clock cycle: sample mid-cycle, compare with the model, advance to just after the edge.
  task automatic cyc();
    @(negedge clk);
    model_step();
    s_ready = req_ready; s_rspv = rsp_valid; s_tmo = lock_tmo;
    check("ready",     64'(req_ready), 64'(e_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(e_rspv));
    check("rsp_rdata", 64'(rsp_rdata), 64'(e_rspd));
    check("lock_tmo",  64'(lock_tmo),  64'(e_tmo));
    check("spi_ovf",   64'(spi_ovf),   64'(e_ovf));
    check("regs",      regs,           e_regs);
    check("spi_rdata", 64'(spi_rdata), 64'(e_spi_rdata));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 1'b0; ena = 1'b1; spi_wr_dv = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rdy [4];
    logic [1:0] rv  [5];
    logic [1:0] pat [4];
    int n_tmo, tmo_at, n_bad;
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;

    idle_in();
    spi_addr = 3'd0; spi_wdata = 8'h00; req_addr = 6'd0; req_wdata = 16'h0;
    rst = 1'b1;
    cyc(); cyc();
    check("rst_regs", regs, 64'h0);
    check("rst_ovf", 64'(spi_ovf), 64'h0);
    rst = 1'b0;

    // 1: SPI write lands next cycle
    spi_wr_dv = 1'b1; spi_addr = 3'd3; spi_wdata = 8'hA5;
    cyc();
    spi_wr_dv = 1'b0;
    check("t1_reg3", 64'(regs[31:24]), 64'hA5);
    check("t1_spi_rdata", 64'(spi_rdata), 64'hA5);

    // 2: two readers alternate, responses one cycle behind
    req_valid = 2'b11; req_we = 2'b00; req_addr = {3'd3, 3'd0};
    for (int i = 0; i < 4; i++) begin
      cyc();
      rdy[i] = s_ready; rv[i] = s_rspv;
    end
    req_valid = 2'b00;
    cyc();
    rv[4] = s_rspv;
    check("t2_rsp_first", 64'(rv[0]), 64'h0);
    for (int i = 0; i < 4; i++) begin
      check("t2_ready", 64'(rdy[i]), 64'(pat[i]));
      check("t2_rsp", 64'(rv[i+1]), 64'(pat[i]));
    end

    // 3: SPI strobe blocks the grant for one cycle
    spi_wr_dv = 1'b1; spi_addr = 3'd6; spi_wdata = 8'h44;
    req_valid = 2'b01; req_we = 2'b01; req_addr = {3'd0, 3'd5}; req_wdata = 16'h003C;
    cyc();
    check("t3_blocked", 64'(s_ready), 64'h0);
    spi_wr_dv = 1'b0;
    cyc();
    check("t3_grant", 64'(s_ready), 64'h1);
    check("t3_reg5", 64'(regs[47:40]), 64'h3C);
    req_valid = 2'b00;

    // 4: locked RMW with two SPI writes parked (overflow) then committed after release
    req_valid = 2'b10; req_we = 2'b00; req_lock = 2'b10; req_addr = {3'd2, 3'd0};
    cyc();
    check("t4_lock_grant", 64'(s_ready), 64'h2);
    req_valid = 2'b00; req_lock = 2'b00;
    spi_wr_dv = 1'b1; spi_addr = 3'd2; spi_wdata = 8'h11;
    cyc();
    spi_wdata = 8'h22;
    cyc();
    spi_wr_dv = 1'b0;
    check("t4_ovf", 64'(spi_ovf), 64'h1);
    check("t4_reg2_held", 64'(regs[23:16]), 64'h00);
    req_valid = 2'b10; req_we = 2'b10; req_wdata = 16'h7F00;
    cyc();
    check("t4_owner_grant", 64'(s_ready), 64'h2);
    check("t4_reg2_7f", 64'(regs[23:16]), 64'h7F);
    req_valid = 2'b00; req_we = 2'b00;
    cyc();
    check("t4_reg2_22", 64'(regs[23:16]), 64'h22);

    // 5: lock idle timeout, then the other requester is served
    req_valid = 2'b01; req_lock = 2'b01; req_addr = {3'd1, 3'd0};
    cyc();
    check("t5_lock_grant", 64'(s_ready), 64'h1);
    req_valid = 2'b10; req_lock = 2'b00;
    n_tmo = 0; tmo_at = -1; n_bad = 0;
    for (int i = 0; i < TMO; i++) begin
      cyc();
      if (s_tmo) begin n_tmo++; tmo_at = i; end
      if (s_ready != 2'b00) n_bad++;
    end
    check("t5_tmo_count", 64'(n_tmo), 64'd1);
    check("t5_tmo_cycle", 64'(tmo_at), 64'(TMO - 1));
    check("t5_no_grant", 64'(n_bad), 64'd0);
    cyc();
    check("t5_req1", 64'(s_ready), 64'h2);
    req_valid = 2'b00;

    // 6: reset while locked with a full pending buffer drops everything
    req_valid = 2'b01; req_lock = 2'b01;
    cyc();
    check("t6_lock_grant", 64'(s_ready), 64'h1);
    req_valid = 2'b00; req_lock = 2'b00;
    spi_wr_dv = 1'b1; spi_addr = 3'd4; spi_wdata = 8'h99;
    cyc();
    spi_wdata = 8'h98;
    cyc();
    spi_wr_dv = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_ovf", 64'(spi_ovf), 64'h0);
    check("t6_regs", regs, 64'h0);
    cyc();
    check("t6_no_commit", regs, 64'h0);
    req_valid = 2'b11;
    cyc();
    check("t6_ptr0", 64'(s_ready), 64'h1);
    idle_in();
    cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      spi_wr_dv = ($urandom_range(0, 4) == 0);
      spi_addr  = 3'($urandom);
      spi_wdata = 8'($urandom);
      req_valid = 2'($urandom);
      req_we    = 2'($urandom);
      req_lock  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      req_addr  = 6'($urandom);
      req_wdata = 16'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
